// File: rtl/rc_eq_pkg.sv
// rc_eq_pkg: shared FSM encoding and the sign-safe absolute-difference helper for rc_eq_monitor
package rc_eq_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAIL    = 2'd2
    } rc_eq_state_t;

    // Callers sign-extend into ABS_W bits and truncate the result to WIDTH+1
    localparam int ABS_W = 64;

    function automatic logic [ABS_W:0] abs_diff(
        input logic signed [ABS_W-1:0] a,
        input logic signed [ABS_W-1:0] b
    );
        logic signed [ABS_W:0] d;
        d = {a[ABS_W-1], a} - {b[ABS_W-1], b};
        return d[ABS_W] ? -d : d;
    endfunction

endpackage

// File: rtl/rc_eq_chan.sv
// rc_eq_chan: per-channel |a-b| tolerance check with a consecutive-miss persistence counter
module rc_eq_chan
    import rc_eq_pkg::*;
#(
    parameter int WIDTH   = 25,
    parameter int TOL     = 0,
    parameter int PERSIST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   err,
    output logic             hit
);

    localparam int PW = $clog2(PERSIST + 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          bad;

    assign err = (WIDTH + 1)'(abs_diff(ABS_W'(signed'(a)), ABS_W'(signed'(b))));
    assign bad = err > (WIDTH + 1)'(TOL);

    always_comb begin
        pcnt_d = pcnt_q;
        if (en) pcnt_d = !bad ? '0 : (pcnt_q == PW'(PERSIST)) ? pcnt_q : pcnt_q + 1'b1;
    end

    assign hit = en && (pcnt_d == PW'(PERSIST));

    always_ff @(posedge clk) begin
        if (rst || restart) pcnt_q <= '0;
        else pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/rc_eq_monitor.sv
// rc_eq_monitor: N-channel equivalence monitor with settle window, persistence filter and sticky diagnostics
module rc_eq_monitor
    import rc_eq_pkg::*;
#(
    parameter int  N_CH    = 2,
    parameter int  WIDTH   = 25,
    parameter int  TOL     = 0,
    parameter int  SETTLE  = 4,
    parameter int  PERSIST = 1,
    parameter int  CNT_W   = 32,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [N_CH*WIDTH-1:0] a,
    input  logic [N_CH*WIDTH-1:0] b,
    output logic                  prop,
    output logic                  fail,
    output logic [CH_W-1:0]       fail_ch,
    output logic [CNT_W-1:0]      fail_cycle,
    output logic [WIDTH:0]        max_err,
    output logic [1:0]            state
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    rc_eq_state_t     state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, fail_cycle_q, fail_cycle_d;
    logic [CH_W-1:0]  fail_ch_q, fail_ch_d, fch;
    logic [WIDTH:0]   max_err_q, max_err_d, emax;
    logic             prop_q, prop_d, en, trig;
    logic [N_CH-1:0]  hit;
    logic [WIDTH:0]   err [N_CH];

    assign en = valid && (state_q == ST_MONITOR);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        rc_eq_chan #(.WIDTH(WIDTH), .TOL(TOL), .PERSIST(PERSIST)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .restart (clear),
            .en      (en),
            .a       (a[c*WIDTH +: WIDTH]),
            .b       (b[c*WIDTH +: WIDTH]),
            .err     (err[c]),
            .hit     (hit[c])
        );
    end

    assign trig = |hit;

    // Descending scan so the lowest triggering index is the one left standing
    always_comb begin
        fch  = '0;
        emax = '0;
        for (int i = N_CH - 1; i >= 0; i--) fch = hit[i] ? CH_W'(i) : fch;
        for (int i = 0; i < N_CH; i++) emax = (err[i] > emax) ? err[i] : emax;
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        cnt_d        = cnt_q;
        prop_d       = prop_q;
        fail_ch_d    = fail_ch_q;
        fail_cycle_d = fail_cycle_q;
        max_err_d    = max_err_q;
        if (valid && state_q != ST_FAIL && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        case (state_q)
            ST_SETTLE: begin
                settle_d = valid ? settle_q + 1'b1 : settle_q;
                if (SETTLE == 0 || (valid && settle_q == SW'(SETTLE - 1))) state_d = ST_MONITOR;
            end
            ST_MONITOR: if (valid) begin
                max_err_d = (emax > max_err_q) ? emax : max_err_q;
                if (trig) begin
                    state_d      = ST_FAIL;
                    prop_d       = 1'b0;
                    fail_ch_d    = fch;
                    fail_cycle_d = cnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= ST_SETTLE;
            settle_q     <= '0;
            cnt_q        <= '0;
            prop_q       <= 1'b1;
            fail_ch_q    <= '0;
            fail_cycle_q <= '0;
            max_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            cnt_q        <= cnt_d;
            prop_q       <= prop_d;
            fail_ch_q    <= fail_ch_d;
            fail_cycle_q <= fail_cycle_d;
            max_err_q    <= max_err_d;
        end
    end

    assign prop       = prop_q;
    assign fail       = ~prop_q;
    assign fail_ch    = fail_ch_q;
    assign fail_cycle = fail_cycle_q;
    assign max_err    = max_err_q;
    assign state      = state_q;

    a_state_legal: assert property (@(posedge clk) state_q inside {ST_SETTLE, ST_MONITOR, ST_FAIL});

endmodule
